// File: rtl/cpu_pkg.sv
// cpu_pkg: constants shared by the decode stage and its hazard sub-module.
//   XLEN          - datapath width
//   OPC_*         - opcode encodings (OPC_LOAD drives load-use detection)
//   *_HI / *_LO   - instruction field bit positions
//   sext16()      - sign-extends a 16-bit immediate to XLEN bits
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [5:0] OPC_LOAD  = 6'h23;
  localparam logic [5:0] OPC_STORE = 6'h2B;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RD_HI  = 25;
  localparam int RD_LO  = 21;
  localparam int RS1_HI = 20;
  localparam int RS1_LO = 16;
  localparam int RS2_HI = 15;
  localparam int RS2_LO = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  function automatic logic [XLEN-1:0] sext16(input logic [15:0] imm);
    return {{(XLEN-16){imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/decode_hazard.sv
// decode_hazard: combinational load-use hazard detection.
// Ports:
//   i_out_valid  - ID/EX register holds a valid instruction
//   i_out_opcode - opcode held in ID/EX
//   i_out_rd     - destination register held in ID/EX
//   i_in_valid   - fetch presents an instruction
//   i_rs1/i_rs2  - source registers of the presented instruction
//   o_hazard     - presented instruction needs a value still being loaded
module decode_hazard #(
  parameter logic [5:0] OPC_LOAD = 6'h23
) (
  input  logic       i_out_valid,
  input  logic [5:0] i_out_opcode,
  input  logic [4:0] i_out_rd,
  input  logic       i_in_valid,
  input  logic [4:0] i_rs1,
  input  logic [4:0] i_rs2,
  output logic       o_hazard
);

  logic w_is_load;
  logic w_rd_match;

  assign w_is_load  = i_out_valid && (i_out_opcode == OPC_LOAD);
  // r0 is hard-wired to zero, so a load into it can never create a dependency.
  assign w_rd_match = (i_out_rd != 5'd0) &&
                      ((i_out_rd == i_rs1) || (i_out_rd == i_rs2));
  assign o_hazard   = w_is_load && w_rd_match && i_in_valid;

endmodule

// File: rtl/decode_stage.sv
// decode_stage: instruction decode with register read, writeback bypass,
// load-use bubble insertion and a valid/ready ID/EX pipeline register.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   in_valid/in_instr/in_ready   - fetch handshake
//   rf_raddr1/2, rf_rdata1/2     - register file read port (combinational)
//   wb_we/wb_addr/wb_data        - writeback port, used for same-cycle bypass
//   flush                        - drop the held instruction, accept nothing
//   out_valid/out_ready          - execute handshake
//   out_opcode..out_imm          - registered ID/EX fields
//   lu_stalls                    - saturating count of load-use bubbles
module decode_stage #(
  parameter int         XLEN     = cpu_pkg::XLEN,
  parameter logic [5:0] OPC_LOAD = cpu_pkg::OPC_LOAD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [31:0]     in_instr,
  output logic            in_ready,
  output logic [4:0]      rf_raddr1,
  output logic [4:0]      rf_raddr2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  input  logic            wb_we,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [XLEN-1:0] out_imm,
  output logic [15:0]     lu_stalls
);
  import cpu_pkg::*;

  logic            r_valid;
  logic [5:0]      r_opcode;
  logic [4:0]      r_rd;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [XLEN-1:0] r_op1;
  logic [XLEN-1:0] r_op2;
  logic [XLEN-1:0] r_imm;
  logic [15:0]     r_lu_stalls;

  logic [5:0]      w_opcode;
  logic [4:0]      w_rd;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [15:0]     w_imm16;
  logic            w_hazard;
  logic            w_advance;
  logic            w_accept;
  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;

  // Operand source: r0 reads zero, a same-cycle writeback wins over the RF.
  function automatic logic [XLEN-1:0] sel_op(
    input logic [4:0]      rs,
    input logic            we,
    input logic [4:0]      waddr,
    input logic [XLEN-1:0] wdata,
    input logic [XLEN-1:0] rdata
  );
    logic [XLEN-1:0] v;
    if (rs == 5'd0) begin
      v = '0;
    end else if (we && (waddr == rs)) begin
      v = wdata;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  assign w_opcode = in_instr[OPC_HI:OPC_LO];
  assign w_rd     = in_instr[RD_HI:RD_LO];
  assign w_rs1    = in_instr[RS1_HI:RS1_LO];
  assign w_rs2    = in_instr[RS2_HI:RS2_LO];
  assign w_imm16  = in_instr[IMM_HI:IMM_LO];

  assign rf_raddr1 = w_rs1;
  assign rf_raddr2 = w_rs2;

  decode_hazard #(
    .OPC_LOAD(OPC_LOAD)
  ) u_hazard (
    .i_out_valid (r_valid),
    .i_out_opcode(r_opcode),
    .i_out_rd    (r_rd),
    .i_in_valid  (in_valid),
    .i_rs1       (w_rs1),
    .i_rs2       (w_rs2),
    .o_hazard    (w_hazard)
  );

  // ID/EX register is free to take a new value (instruction or bubble).
  assign w_advance = (!r_valid || out_ready) && !flush;
  assign in_ready  = !rst && w_advance && !w_hazard;
  assign w_accept  = in_valid && in_ready;

  assign w_op1 = sel_op(w_rs1, wb_we, wb_addr, wb_data, rf_rdata1);
  assign w_op2 = sel_op(w_rs2, wb_we, wb_addr, wb_data, rf_rdata2);

  // ID/EX pipeline register; data fields only change on an accepted instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_opcode <= 6'd0;
      r_rd     <= 5'd0;
      r_rs1    <= 5'd0;
      r_rs2    <= 5'd0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_imm    <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_advance) begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_opcode <= w_opcode;
        r_rd     <= w_rd;
        r_rs1    <= w_rs1;
        r_rs2    <= w_rs2;
        r_op1    <= w_op1;
        r_op2    <= w_op2;
        r_imm    <= sext16(w_imm16);
      end
    end
  end

  // Load-use bubble counter; a flushed cycle is not a bubble, so it is not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lu_stalls <= 16'd0;
    end else if (w_advance && w_hazard && (r_lu_stalls != 16'hFFFF)) begin
      r_lu_stalls <= r_lu_stalls + 16'd1;
    end
  end

  assign out_valid  = r_valid;
  assign out_opcode = r_opcode;
  assign out_rd     = r_rd;
  assign out_rs1    = r_rs1;
  assign out_rs2    = r_rs2;
  assign out_op1    = r_op1;
  assign out_op2    = r_op2;
  assign out_imm    = r_imm;
  assign lu_stalls  = r_lu_stalls;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors with hand-computed expectations.
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [31:0] out_op1, out_op2, out_imm;
  logic [15:0] lu_stalls;

  logic [31:0] regs [32];
  int n_vec;
  int n_err;
  logic [31:0] held_op1;

  assign rf_rdata1 = regs[rf_raddr1];
  assign rf_rdata2 = regs[rf_raddr2];

  decode_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm),
    .lu_stalls(lu_stalls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance one edge and move 1ns past it so registered outputs are settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [10:0] lo);
    return {op, rd, rs1, rs2, lo};
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + i;
    regs[0] = 32'hDEAD_0000;
    regs[3] = 32'h0000_0011;
    regs[5] = 32'h0000_0000;
    rst = 1'b1; in_valid = 1'b1; in_instr = mk(6'h01, 5'd2, 5'd3, 5'd4, 11'h010);
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; flush = 1'b0; out_ready = 1'b1;

    // Reset state
    step(); step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_op1", out_op1, 32'd0);
    chk("rst_lu", {16'd0, lu_stalls}, 32'd0);

    // Basic decode, 1-cycle latency
    rst = 1'b0; #1;
    chk("acc_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("acc_valid", {31'd0, out_valid}, 32'd1);
    chk("acc_op1", out_op1, 32'h0000_0011);
    chk("acc_op2", out_op2, 32'h1000_0004);
    chk("acc_rd", {27'd0, out_rd}, 32'd2);
    chk("acc_opc", {26'd0, out_opcode}, 32'h01);
    chk("acc_imm", out_imm, 32'h0000_2010);

    // Writeback bypass on rs2, r0 forced to zero on rs1
    in_instr = mk(6'h02, 5'd1, 5'd0, 5'd5, 11'h000);
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_ABCD;
    step();
    chk("byp_op2", out_op2, 32'h0000_ABCD);
    chk("byp_r0_op1", out_op1, 32'd0);
    in_instr = mk(6'h02, 5'd1, 5'd0, 5'd0, 11'h000);
    wb_addr = 5'd0;
    step();
    chk("byp_r0_op2", out_op2, 32'd0);

    // Negative immediate sign extension
    wb_we = 1'b0;
    in_instr = mk(6'h03, 5'd6, 5'd8, 5'h10, 11'h000);
    step();
    chk("imm_neg", out_imm, 32'hFFFF_8000);
    chk("imm_op1", out_op1, 32'h1000_0008);

    // Load-use: LOAD r7 then consumer of r7
    in_instr = mk(6'h23, 5'd7, 5'd1, 5'd2, 11'h000);
    step();
    chk("ld_opc", {26'd0, out_opcode}, 32'h23);
    in_instr = mk(6'h01, 5'd9, 5'd7, 5'd2, 11'h000); #1;
    chk("lu_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    chk("lu_bubble", {31'd0, out_valid}, 32'd0);
    chk("lu_count", {16'd0, lu_stalls}, 32'd1);
    chk("lu_ready_after", {31'd0, in_ready}, 32'd1);
    step();
    chk("lu_issue_valid", {31'd0, out_valid}, 32'd1);
    chk("lu_issue_rd", {27'd0, out_rd}, 32'd9);
    chk("lu_issue_op1", out_op1, 32'h1000_0007);

    // Load into r0 never stalls
    in_instr = mk(6'h23, 5'd0, 5'd1, 5'd2, 11'h000);
    step();
    in_instr = mk(6'h01, 5'd10, 5'd8, 5'd0, 11'h000); #1;
    chk("ld_r0_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("ld_r0_rd", {27'd0, out_rd}, 32'd10);

    // Backpressure; a writeback to the held source must not refresh it
    held_op1 = out_op1;
    out_ready = 1'b0;
    in_instr = mk(6'h04, 5'd11, 5'd1, 5'd2, 11'h000);
    wb_we = 1'b1; wb_addr = 5'd8; wb_data = 32'h5555_5555;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      step();
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_rd", {27'd0, out_rd}, 32'd10);
      chk("bp_op1", out_op1, held_op1);
    end
    wb_we = 1'b0;
    out_ready = 1'b1; #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("bp_release_rd", {27'd0, out_rd}, 32'd11);

    // Flush with held instruction under backpressure
    out_ready = 1'b0; flush = 1'b1; #1;
    chk("fl_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    flush = 1'b0; out_ready = 1'b1;

    // Flush during a hazard: no count
    in_instr = mk(6'h23, 5'd12, 5'd1, 5'd2, 11'h000);
    step();
    in_instr = mk(6'h01, 5'd13, 5'd1, 5'd12, 11'h000);
    flush = 1'b1;
    step();
    chk("flhz_valid", {31'd0, out_valid}, 32'd0);
    chk("flhz_count", {16'd0, lu_stalls}, 32'd1);
    flush = 1'b0;

    // Saturation at 0xFFFF
    in_instr = mk(6'h23, 5'd12, 5'd1, 5'd2, 11'h000);
    step();
    force dut.r_lu_stalls = 16'hFFFF;
    #1;
    release dut.r_lu_stalls;
    in_instr = mk(6'h01, 5'd13, 5'd12, 5'd1, 11'h000); #1;
    chk("sat_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    chk("sat_count", {16'd0, lu_stalls}, 32'h0000_FFFF);

    // Reset mid-stall discards the held instruction
    in_instr = mk(6'h05, 5'd14, 5'd1, 5'd2, 11'h000);
    step();
    out_ready = 1'b0;
    in_instr = mk(6'h06, 5'd15, 5'd3, 5'd2, 11'h000);
    step();
    rst = 1'b1;
    step();
    chk("rst2_valid", {31'd0, out_valid}, 32'd0);
    chk("rst2_rd", {27'd0, out_rd}, 32'd0);
    chk("rst2_lu", {16'd0, lu_stalls}, 32'd0);
    rst = 1'b0; #1;
    chk("rst2_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("rst2_accept_valid", {31'd0, out_valid}, 32'd1);
    chk("rst2_accept_rd", {27'd0, out_rd}, 32'd15);
    chk("rst2_accept_op1", out_op1, 32'h0000_0011);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter: XLEN, 32, datapath width.
REQ-002 Parameter: OPC_LOAD, 6'h23, opcode treated as a load for hazard detection.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  fetch presents an instruction.
REQ-006 in_instr  in  32  fields: opcode[31:26], rd[25:21], rs1[20:16], rs2[15:11], imm[15:0].
REQ-007 in_ready  out  1  decode accepts in_instr this cycle.
REQ-008 rf_raddr1, rf_raddr2  out  5 each  register file read addresses (= in_instr rs1, rs2).
REQ-009 rf_rdata1, rf_rdata2  in  32 each  register file read data, combinational from addresses.
REQ-010 wb_we, wb_addr, wb_data  in  1/5/32  writeback port, same values driven into register file write port.
REQ-011 flush  in  1  discard the held instruction; do not accept this cycle.
REQ-012 out_valid  out  1  ID/EX register holds a valid instruction.
REQ-013 out_ready  in  1  execute consumes the held instruction this cycle.
REQ-014 out_opcode 6, out_rd 5, out_rs1 5, out_rs2 5, out_op1 32, out_op2 32, out_imm 32  out  registered ID/EX fields.
REQ-015 lu_stalls  out  16  saturating count of load-use bubbles inserted.

Function
REQ-016 The ID/EX register SHALL be loaded when (not out_valid or out_ready) and not flush; the load inserts the instruction if in_valid and in_ready, otherwise a bubble (out_valid=0).
REQ-017 in_ready SHALL be 1 iff (not out_valid or out_ready) and not flush and no load-use hazard.
REQ-018 Load-use hazard: out_valid, out_opcode==OPC_LOAD, out_rd!=0, out_rd equal to in_instr rs1 or rs2, and in_valid.
REQ-019 On a load-use hazard with out_ready=1, a bubble SHALL be loaded and lu_stalls incremented by 1, saturating at 16'hFFFF.
REQ-020 Operand select for each source: address 0 -> 0; else wb_we and wb_addr==rs -> wb_data (same-cycle write bypass); else rf_rdata.
REQ-021 out_imm SHALL be imm[15:0] sign-extended to 32 bits; out_opcode, out_rd, out_rs1, out_rs2 copy instruction fields.
REQ-022 Decode latency SHALL be exactly 1 cycle from acceptance to out_valid=1.
REQ-023 With out_valid=1 and out_ready=0, all out_* fields SHALL hold unchanged.
REQ-024 A held instruction whose source matches a wb write while stalled SHALL NOT be refreshed; execute forwarding covers it.
REQ-025 flush SHALL set out_valid=0 on the next edge regardless of out_ready; a flush during a hazard inserts no count.
REQ-026 Priority: rst > flush > hazard bubble > normal load.

Reset
REQ-027 On rst: out_valid=0, all out_* data fields=0, lu_stalls=0; in_ready=0 while rst is high.
REQ-028 rst asserted mid-stall SHALL discard the held instruction; the first post-reset cycle accepts normally.

Structure
REQ-029 Shared package cpu_pkg SHALL hold opcode constants (OPC_LOAD etc.), instruction field bit positions, and XLEN.
REQ-030 The hazard compare (REQ-018) SHALL be a combinational sub-module decode_hazard; the remainder stays in decode_stage.
REQ-031 No latches; the ID/EX register is the only state besides lu_stalls.

Verification
REQ-032 Reset then in_instr rs1=3 with rf_rdata1=0x11 -> next cycle out_valid=1, out_op1=0x11.
REQ-033 Bypass: rs2=5, wb_we=1, wb_addr=5, wb_data=0xABCD, rf_rdata2=0 -> out_op2=0xABCD; same with rs2=0 -> out_op2=0.
REQ-034 Load-use: held LOAD rd=7, out_ready=1, next instr rs1=7 -> in_ready=0, bubble for one cycle, lu_stalls=1, instr issued the following cycle.
REQ-035 Backpressure: out_ready=0 for 3 cycles -> out_* stable, in_ready=0; release -> next instr accepted.
REQ-036 flush with out_valid=1, out_ready=0 -> out_valid=0 next cycle, in_ready=0 during flush.
REQ-037 imm=16'h8000 -> out_imm=0xFFFF8000; lu_stalls forced to 0xFFFF then hazard -> stays 0xFFFF.
